// File: rtl/bky_pkg.sv
// ============================================================================
// Module  : bky_pkg
// Brief   : Shared types and defaults for the Buckeye serial shift controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bky_pkg;

  localparam int NCHIP_DEF = 6;
  localparam int NBITS_DEF = 48;
  localparam int CLKDIV_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_LOAD  = 3'd2,
    S_LOW   = 3'd3,
    S_HIGH  = 3'd4,
    S_STORE = 3'd5,
    S_FIN   = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bky_clk_gen.sv
// ============================================================================
// Module  : bky_clk_gen
// Brief   : AMPCLK phase divider; strobes the last cycle of each LOW/HIGH phase.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bky_clk_gen
  import bky_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic i_cmsclk,
  input  logic i_rst_b,
  input  logic i_lo,
  input  logic i_hi,
  output logic o_lo_last,
  output logic o_hi_last
);

  localparam logic [CLKDIV_W-1:0] c_div_last = CLKDIV_W'(CLKDIV - 1);

  logic [CLKDIV_W-1:0] r_cnt;
  logic                w_en;
  logic                w_last;

  assign w_en   = i_lo | i_hi;
  assign w_last = w_en && (r_cnt == c_div_last);

  // LOW and HIGH are back to back, so wrapping at the last cycle aligns phases.
  always_ff @(posedge i_cmsclk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_cnt <= '0;
    end else if (!w_en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CLKDIV_W'(1);
    end
  end

  assign o_lo_last = w_last & i_lo;
  assign o_hi_last = w_last & i_hi;

endmodule

`default_nettype wire

// File: rtl/bky_shift_ctrl.sv
// ============================================================================
// Module  : bky_shift_ctrl
// Brief   : Serially loads each unmasked Buckeye chip and returns its readback.
//           Define BKY_RB_CHECK_EN for a verifying second pass with ERR flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bky_shift_ctrl
  import bky_pkg::*;
#(
  parameter int NCHIP  = NCHIP_DEF,
  parameter int NBITS  = NBITS_DEF,
  parameter int CLKDIV = 4
) (
  input  logic             i_cmsclk,
  input  logic             i_rst_b,
  input  logic             i_start,
  input  logic [NCHIP-1:0] i_mask,
  output logic [2:0]       o_chip_sel,
  input  logic [NBITS-1:0] i_sh_data,
  output logic [NBITS-1:0] o_rb_data,
  output logic             o_rb_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [NCHIP-1:0] o_err,
  output logic [NCHIP-1:0] o_ampclk,
  output logic [NCHIP-1:0] o_ampin,
  input  logic [NCHIP-1:0] i_ampout
);

  localparam int              BIT_W      = $clog2(NBITS);
  localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(NBITS - 1);
  localparam logic [2:0]      c_idx_end  = 3'(NCHIP);

  state_t             r_state;
  state_t             w_next;
  state_t             w_pass_end;
  logic [NCHIP-1:0]   r_mask;
  logic [2:0]         r_idx;
  logic [BIT_W-1:0]   r_bit;
  logic [NBITS-1:0]   r_shreg;
  logic [NBITS-1:0]   r_rb;
  logic [NCHIP-1:0]   w_sel_oh;
  logic               w_sel_mask;
  logic               w_ampout_sel;
  logic               w_lo_last;
  logic               w_hi_last;

  // One-hot of idx; becomes all-zero once idx reaches NCHIP.
  assign w_sel_oh     = NCHIP'(1) << r_idx;
  assign w_sel_mask   = |(r_mask & w_sel_oh);
  assign w_ampout_sel = |(i_ampout & w_sel_oh);

  bky_clk_gen #(
    .CLKDIV (CLKDIV)
  ) u_clk_gen (
    .i_cmsclk  (i_cmsclk),
    .i_rst_b   (i_rst_b),
    .i_lo      (r_state == S_LOW),
    .i_hi      (r_state == S_HIGH),
    .o_lo_last (w_lo_last),
    .o_hi_last (w_hi_last)
  );

`ifdef BKY_RB_CHECK_EN
  logic             r_pass;
  logic [NCHIP-1:0] r_err;

  assign w_pass_end = r_pass ? S_STORE : S_LOAD;
  assign o_err      = r_err;

  always_ff @(posedge i_cmsclk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_pass <= 1'b0;
      r_err  <= '0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_err <= '0;
      end
      if (r_state == S_HIGH && w_hi_last && r_bit == c_bit_last) begin
        r_pass <= ~r_pass;
      end
      if (r_state == S_STORE && r_rb != i_sh_data) begin
        r_err <= r_err | w_sel_oh;
      end
    end
  end
`else
  assign w_pass_end = S_STORE;
  assign o_err      = '0;
`endif

  always_ff @(posedge i_cmsclk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    o_ampclk   = '0;
    o_ampin    = '0;
    o_rb_valid = 1'b0;
    o_done     = 1'b0;
    o_busy     = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = S_SEL;
      end
      S_SEL: begin
        if (r_idx == c_idx_end) w_next = S_FIN;
        else if (w_sel_mask)    w_next = S_LOAD;
      end
      S_LOAD: w_next = S_LOW;
      S_LOW: begin
        if (r_shreg[0]) o_ampin = w_sel_oh;
        if (w_lo_last)  w_next  = S_HIGH;
      end
      S_HIGH: begin
        // Data is held through HIGH so it is stable on the rising AMPCLK edge.
        o_ampclk = w_sel_oh;
        if (r_shreg[0]) o_ampin = w_sel_oh;
        if (w_hi_last)  w_next  = (r_bit == c_bit_last) ? w_pass_end : S_LOW;
      end
      S_STORE: begin
        o_rb_valid = 1'b1;
        w_next     = S_SEL;
      end
      S_FIN: begin
        o_done = 1'b1;
        o_busy = 1'b0;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_cmsclk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_mask  <= '0;
      r_idx   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_rb    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mask <= i_mask;
            r_idx  <= '0;
          end
        end
        S_SEL: begin
          if (r_idx != c_idx_end && !w_sel_mask) r_idx <= r_idx + 3'd1;
        end
        S_LOAD: begin
          r_shreg <= i_sh_data;
          r_bit   <= '0;
        end
        S_LOW: begin
          if (w_lo_last) r_rb <= {w_ampout_sel, r_rb[NBITS-1:1]};
        end
        S_HIGH: begin
          if (w_hi_last) begin
            r_shreg <= r_shreg >> 1;
            r_bit   <= r_bit + BIT_W'(1);
          end
        end
        S_STORE: r_idx <= r_idx + 3'd1;
        default: ;
      endcase
    end
  end

  assign o_chip_sel = r_idx;
  assign o_rb_data  = r_rb;

endmodule

`default_nettype wire
